// File: rtl/roi_scan_ctrl.sv
// Sequencer for the serial ROI harness: shifts a stimulus vector into di, issues the two
// latch/capture strobes, then deserialises do_ser into result.
module roi_scan_ctrl #(
  parameter int unsigned DIN_N      = 256,
  parameter int unsigned DOUT_N     = 256,
  parameter int unsigned SETTLE_CYC = 4,
  parameter int unsigned IO_LAT     = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DIN_N-1:0]  vec_in,
  output logic              di,
  output logic              stb,
  input  logic              do_ser,
  output logic              busy,
  output logic              done,
  output logic [DOUT_N-1:0] result
);

  localparam int unsigned MaxA   = (DIN_N > DOUT_N) ? DIN_N : DOUT_N;
  localparam int unsigned MaxB   = (SETTLE_CYC > IO_LAT) ? SETTLE_CYC : IO_LAT;
  localparam int unsigned MaxLen = (MaxA > MaxB) ? MaxA : MaxB;
  localparam int unsigned CntW   = $clog2(MaxLen + 1);

  typedef enum logic [3:0] {
    StIdle, StLoad, StStbA, StSettle, StReload, StStbB, StLat, StUnload, StDone
  } state_e;

  state_e           r_state, w_state_d;
  logic [CntW-1:0]  r_cnt, w_cnt_d, w_cnt_dec;
  logic [DIN_N-1:0] r_vsh, w_vsh_d;
  logic [DIN_N-1:0] r_sh, w_sh_d;
  logic             w_last;
  logic             w_di_d, w_stb_d, w_busy_d, w_done_d;

  assign w_last    = (r_cnt == CntW'(1));
  assign w_cnt_dec = r_cnt - CntW'(1);

  // State register; outputs are registered from the next-state decode so they align with state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_vsh   <= '0;
      r_sh    <= '0;
      di      <= 1'b0;
      stb     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_vsh   <= w_vsh_d;
      r_sh    <= w_sh_d;
      di      <= w_di_d;
      stb     <= w_stb_d;
      busy    <= w_busy_d;
      done    <= w_done_d;
      if (r_state == StUnload) begin
        result <= {result[DOUT_N-2:0], do_ser};
      end
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_vsh_d   = r_vsh;
    w_sh_d    = r_sh;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_state_d = StLoad;
          w_cnt_d   = CntW'(DIN_N);
          w_vsh_d   = vec_in;
          w_sh_d    = vec_in;
        end
      end
      StLoad, StReload: begin
        w_sh_d = r_sh << 1;
        if (w_last) begin
          w_state_d = (r_state == StLoad) ? StStbA : StStbB;
          w_cnt_d   = '0;
        end else begin
          w_cnt_d = w_cnt_dec;
        end
      end
      StStbA: begin
        if (SETTLE_CYC != 0) begin
          w_state_d = StSettle;
          w_cnt_d   = CntW'(SETTLE_CYC);
        end else begin
          w_state_d = StReload;
          w_cnt_d   = CntW'(DIN_N);
          w_sh_d    = r_vsh;
        end
      end
      StSettle: begin
        if (w_last) begin
          // Harness din_shr was flushed with zeros; re-shift the shadow copy.
          w_state_d = StReload;
          w_cnt_d   = CntW'(DIN_N);
          w_sh_d    = r_vsh;
        end else begin
          w_cnt_d = w_cnt_dec;
        end
      end
      StStbB: begin
        if (IO_LAT != 0) begin
          w_state_d = StLat;
          w_cnt_d   = CntW'(IO_LAT);
        end else begin
          w_state_d = StUnload;
          w_cnt_d   = CntW'(DOUT_N);
        end
      end
      StLat: begin
        if (w_last) begin
          w_state_d = StUnload;
          w_cnt_d   = CntW'(DOUT_N);
        end else begin
          w_cnt_d = w_cnt_dec;
        end
      end
      StUnload: begin
        if (w_last) begin
          w_state_d = StDone;
          w_cnt_d   = '0;
        end else begin
          w_cnt_d = w_cnt_dec;
        end
      end
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_di_d   = 1'b0;
    w_stb_d  = 1'b0;
    w_busy_d = 1'b0;
    w_done_d = 1'b0;
    unique case (w_state_d)
      StLoad, StReload: begin
        w_di_d   = w_sh_d[DIN_N-1];
        w_busy_d = 1'b1;
      end
      StStbA, StStbB: begin
        w_stb_d  = 1'b1;
        w_busy_d = 1'b1;
      end
      StSettle, StLat, StUnload: w_busy_d = 1'b1;
      StDone:                    w_done_d = 1'b1;
      default:                   ;
    endcase
  end

endmodule

// File: tb/tb_roi_scan_ctrl.sv
// Bench for roi_scan_ctrl: two instances (IO_LAT 0 and 2) each driving a behavioural harness
// whose roi computes dout = ~din; expected strobes and results go through a scoreboard.
module tb_roi_scan_ctrl;

  typedef struct packed {
    logic [31:0] cyc;
    logic [7:0]  v;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  ev_t dq[2][$];
  ev_t sq[2][$];

  logic       start0 = 1'b0, start1 = 1'b0;
  logic [7:0] vec0 = 8'h00, vec1 = 8'h00;
  logic       di0, stb0, busy0, done0, do0;
  logic       di1, stb1, busy1, done1, do1;
  logic [7:0] res0, res1;

  // Harness models: din_shr shifts every edge, stb latches din and captures dout.
  logic [7:0] shr0 = 8'h00, din0 = 8'h00, dsh0 = 8'h00;
  logic [7:0] shr1 = 8'h00, din1 = 8'h00, dsh1 = 8'h00;
  logic [1:0] dly1 = 2'b00;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    shr0 <= {shr0[6:0], di0};
    if (stb0) begin
      din0 <= shr0;
      dsh0 <= ~din0;
    end else begin
      dsh0 <= {dsh0[6:0], 1'b0};
    end
  end
  assign do0 = dsh0[7];

  always @(posedge clk) begin
    shr1 <= {shr1[6:0], di1};
    if (stb1) begin
      din1 <= shr1;
      dsh1 <= ~din1;
    end else begin
      dsh1 <= {dsh1[6:0], 1'b0};
    end
    dly1 <= {dly1[0], dsh1[7]};
  end
  assign do1 = dly1[1];

  roi_scan_ctrl #(.DIN_N(8), .DOUT_N(8), .SETTLE_CYC(4), .IO_LAT(0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .vec_in(vec0), .di(di0), .stb(stb0),
    .do_ser(do0), .busy(busy0), .done(done0), .result(res0)
  );

  roi_scan_ctrl #(.DIN_N(8), .DOUT_N(8), .SETTLE_CYC(4), .IO_LAT(2)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .vec_in(vec1), .di(di1), .stb(stb1),
    .do_ser(do1), .busy(busy1), .done(done1), .result(res1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic mon(input int id, input logic s, input logic d, input logic [7:0] r,
                     input logic [7:0] shr);
    ev_t e;
    if (s === 1'b1) begin
      if (sq[id].size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL stb dut%0d: got pulse at cycle %0d, expected none", id, cyc);
      end else begin
        e = sq[id].pop_front();
        check($sformatf("stb cycle dut%0d", id), cyc, e.cyc);
        check($sformatf("din_shr at stb dut%0d", id), {24'h0, shr}, {24'h0, e.v});
      end
    end
    if (d === 1'b1) begin
      if (dq[id].size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL done dut%0d: got pulse at cycle %0d, expected none", id, cyc);
      end else begin
        e = dq[id].pop_front();
        check($sformatf("done cycle dut%0d", id), cyc, e.cyc);
        check($sformatf("result dut%0d", id), {24'h0, r}, {24'h0, e.v});
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, stb0, done0, res0, shr0);
    mon(1, stb1, done1, res1, shr1);
  end

  // Queue the expectations for a scan accepted at edge n (LOAD cycle 0 sampled at cyc == n).
  task automatic expect_scan(input int id, input int n, input logic [7:0] v, input int lat);
    sq[id].push_back('{cyc: n + 8, v: v});
    sq[id].push_back('{cyc: n + 21, v: v});
    dq[id].push_back('{cyc: n + 30 + lat, v: ~v});
  endtask

  task automatic issue(input int id, input logic [7:0] v, input int lat, output int n);
    n = cyc + 1;
    if (id == 0) begin start0 = 1'b1; vec0 = v; end
    else         begin start1 = 1'b1; vec1 = v; end
    expect_scan(id, n, v, lat);
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
    vec0   = ~v;
    vec1   = ~v;
    check($sformatf("busy after accept dut%0d", id), {31'h0, (id == 0) ? busy0 : busy1}, 1);
  endtask

  task automatic wait_drain();
    int k = 0;
    int left;
    left = dq[0].size() + dq[1].size() + sq[0].size() + sq[1].size();
    while (left != 0 && k < 200) begin
      @(negedge clk);
      k++;
      left = dq[0].size() + dq[1].size() + sq[0].size() + sq[1].size();
    end
    if (left != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain timeout: got %0d events outstanding, expected 0", left);
      dq[0].delete(); dq[1].delete(); sq[0].delete(); sq[1].delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int n, n2;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle outputs", {20'h0, di0, stb0, busy0, done0, res0}, 0);
    end

    issue(0, 8'hA5, 0, n);
    wait_drain();

    // Start pulse with a different vector in the middle of UNLOAD must be ignored.
    issue(0, 8'hC0, 0, n);
    while (cyc < n + 24) @(negedge clk);
    start0 = 1'b1;
    vec0   = 8'hFF;
    @(negedge clk);
    start0 = 1'b0;
    wait_drain();
    repeat (40) @(negedge clk);

    // Back-to-back with start held: second accept lands on the IDLE cycle after DONE.
    n = cyc + 1;
    start0 = 1'b1;
    vec0   = 8'h01;
    expect_scan(0, n, 8'h01, 0);
    @(negedge clk);
    vec0 = 8'h80;
    n2 = n + 32;
    expect_scan(0, n2, 8'h80, 0);
    while (cyc < n2) @(negedge clk);
    start0 = 1'b0;
    wait_drain();

    // Abort in RELOAD: only the first strobe may appear, outputs clear next cycle.
    n = cyc + 1;
    start0 = 1'b1;
    vec0   = 8'hE7;
    sq[0].push_back('{cyc: n + 8, v: 8'hE7});
    @(negedge clk);
    start0 = 1'b0;
    while (cyc < n + 15) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort outputs", {20'h0, di0, stb0, busy0, done0, res0}, 0);
    wait_drain();
    repeat (30) @(negedge clk);
    issue(0, 8'h3C, 0, n);
    wait_drain();

    issue(1, 8'h96, 2, n);
    wait_drain();
    repeat (40) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test by %0t, expected earlier finish", $time);
    $fatal(1, "watchdog");
  end

endmodule
